// File: rtl/store_buffer.sv
// Store buffer between a pipeline and a single-port memory: stores queue up and drain when the port is free.
// Optional store-to-load forwarding is enabled by defining SB_FWD_EN; otherwise matching loads wait for the drain.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0] valid_q;
  logic [15:0]      addr_q [DEPTH];
  logic [15:0]      data_q [DEPTH];
  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [CW-1:0]    count_q;
  logic             rsp_valid_q;
  logic [15:0]      rsp_rdata_q;

  logic [DEPTH-1:0] hit_vec;
  logic [PW-1:0]    hit_idx;
  logic             hit_any;
  logic             is_load;
  logic             is_store;
  logic             port_read;
  logic             load_stall;
  logic             drain;
  logic             coalesce;
  logic             push_ok;
  logic             push;
  logic             load_acc;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    assign hit_vec[gi] = valid_q[gi] && (addr_q[gi] == req_addr);
  end

  // Addresses in the buffer are unique, so at most one bit of hit_vec is set.
  always_comb begin
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (hit_vec[i]) hit_idx = PW'(i);
    end
  end

  assign hit_any  = |hit_vec;
  assign is_load  = req_valid && !req_wr;
  assign is_store = req_valid && req_wr;

`ifdef SB_FWD_EN
  assign load_stall = 1'b0;
`else
  assign load_stall = is_load && hit_any;
`endif

  // A held (matching) load leaves the port free so the matching entry can drain.
  assign port_read = is_load && !hit_any && rst;
  assign drain     = !port_read && (count_q != '0);
  assign coalesce  = is_store && hit_any && !(drain && (hit_idx == head_q));
  assign push_ok   = (count_q < CW'(DEPTH)) || drain;
  assign push      = is_store && !coalesce && push_ok;
  assign load_acc  = is_load && !load_stall;
  assign req_ready = !load_stall && !(is_store && !coalesce && !push_ok);
  assign empty     = (count_q == '0);

  always_comb begin
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (port_read) begin
      mem_en   = 1'b1;
      mem_addr = req_addr;
    end else if (drain) begin
      mem_en    = 1'b1;
      mem_wr    = 1'b1;
      mem_addr  = addr_q[head_q];
      mem_wdata = data_q[head_q];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (drain) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PW'(1);
      end
      if (coalesce) data_q[hit_idx] <= req_wdata;
      // When full, tail equals head; the push must win over the pop's invalidation.
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        addr_q[tail_q]  <= req_addr;
        data_q[tail_q]  <= req_wdata;
        tail_q          <= tail_q + PW'(1);
      end
      count_q     <= count_q + CW'(push) - CW'(drain);
      rsp_valid_q <= load_acc;
      if (load_acc) rsp_rdata_q <= port_read ? mem_rdata : data_q[hit_idx];
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
